// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, types and combinational round primitives.
//   Byte order: byte0 = [127:120], column-major (bytes 0..3 form column 0).
//   Provides xtime/mul2/mul3, GF(2^8) multiply, S-box, SubWord, and the
//   SubBytes / ShiftRows / MixColumns block transforms.
package aes_pkg;

   localparam int unsigned AES_NR    = 10;
   localparam logic [7:0]  RCON_INIT = 8'h01;
   localparam int unsigned AES_NB    = 4;   // columns (and rows) per state
   localparam int unsigned AES_NBYTE = 16;

   typedef logic [127:0]     block_t;
   // Ascending packed range: element 0 occupies [127:120].
   typedef logic [0:15][7:0] block_bytes_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } ctrl_state_t;

   function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col);
      return row + AES_NB * col;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = '0;
      aa = a;
      bb = b;
      for (int unsigned i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xtime(aa);
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (b^254, 0 maps to 0) followed by the
   // affine transform, instead of a 256-entry table.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = b;
      inv = 8'h01;
      for (int unsigned i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic block_t sub_bytes(input block_t s);
      block_bytes_t bi;
      block_bytes_t bo;
      bi = s;
      bo = '0;
      for (int unsigned k = 0; k < AES_NBYTE; k++)
         bo[4'(k)] = sbox(bi[4'(k)]);
      return bo;
   endfunction

   // Row r is rotated left by r columns.
   function automatic block_t shift_rows(input block_t s);
      block_bytes_t bi;
      block_bytes_t bo;
      bi = s;
      bo = '0;
      for (int unsigned c = 0; c < AES_NB; c++)
         for (int unsigned r = 0; r < AES_NB; r++)
            bo[4'(byte_idx(r, c))] = bi[4'(byte_idx(r, (c + r) % AES_NB))];
      return bo;
   endfunction

   function automatic block_t mix_columns(input block_t s);
      block_bytes_t bi;
      block_bytes_t bo;
      logic [7:0] a0, a1, a2, a3;
      bi = s;
      bo = '0;
      for (int unsigned c = 0; c < AES_NB; c++) begin
         a0 = bi[4'(byte_idx(0, c))];
         a1 = bi[4'(byte_idx(1, c))];
         a2 = bi[4'(byte_idx(2, c))];
         a3 = bi[4'(byte_idx(3, c))];
         bo[4'(byte_idx(0, c))] = mul2(a0) ^ mul3(a1) ^ a2 ^ a3;
         bo[4'(byte_idx(1, c))] = a0 ^ mul2(a1) ^ mul3(a2) ^ a3;
         bo[4'(byte_idx(2, c))] = a0 ^ a1 ^ mul2(a2) ^ mul3(a3);
         bo[4'(byte_idx(3, c))] = mul3(a0) ^ a1 ^ a2 ^ mul2(a3);
      end
      return bo;
   endfunction

endpackage

// File: rtl/aes128_key_step.sv
// aes128_key_step: combinational AES-128 key schedule step.
//   key_in  [127:0]  current round key (w0 = [127:96] .. w3 = [31:0])
//   rcon    [7:0]    round constant for the key being produced
//   key_out [127:0]  next round key
module aes128_key_step
   import aes_pkg::*;
(
   input  logic [127:0] key_in,
   input  logic [7:0]   rcon,
   output logic [127:0] key_out
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] t;
   logic [31:0] n0, n1, n2, n3;

   always_comb begin
      w0 = key_in[127:96];
      w1 = key_in[95:64];
      w2 = key_in[63:32];
      w3 = key_in[31:0];
      // SubWord(RotWord(w3)) ^ {rcon, 0, 0, 0}
      t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      key_out = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/aes128_round_ctrl.sv
// aes128_round_ctrl: iterative AES-128 encryption engine (one shared round
// datapath, round keys expanded on the fly).
//   clk, rst           clock (rising edge), async active-high reset
//   in_valid/in_ready  plaintext/key handshake (inputs sampled on handshake only)
//   plaintext, key     128-bit block and cipher key, byte0 = [127:120]
//   out_valid/out_ready ciphertext handshake; result held under backpressure
//   ciphertext         128-bit result
//   busy               high while rounds are running
// Parameters: NR (must be 10), PIPE_RND (0: 1 cycle/round, 1: 2 cycles/round)
module aes128_round_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned NR       = 10,
   parameter int unsigned PIPE_RND = 0
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic         busy
);

   if (NR != AES_NR) begin : g_nr_check
      $error("aes128_round_ctrl supports only NR = 10");
   end

   localparam bit         PIPE     = (PIPE_RND != 0);
   localparam logic [3:0] RND_LAST = 4'(NR);

   ctrl_state_t  st;
   logic [3:0]   rnd;
   logic [7:0]   rcon;
   block_t       state_reg;
   block_t       key_reg;
   block_t       pipe_reg;
   logic         half;     // PIPE only: ShiftRows result captured, second half pending
   logic         fin;      // final round written, result transfer pending

   block_t       next_key;
   block_t       sb_sr;
   block_t       mc_in;
   block_t       round_out;
   logic         take;

   aes128_key_step u_key_step (
      .key_in  (key_reg),
      .rcon    (rcon),
      .key_out (next_key)
   );

   assign in_ready = (st == ST_IDLE) || ((st == ST_DONE) && out_ready);

   always_comb begin
      take      = in_valid && in_ready;
      sb_sr     = shift_rows(sub_bytes(state_reg));
      mc_in     = PIPE ? pipe_reg : sb_sr;
      round_out = ((rnd == RND_LAST) ? mc_in : mix_columns(mc_in)) ^ next_key;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= ST_IDLE;
         rnd        <= '0;
         rcon       <= '0;
         state_reg  <= '0;
         key_reg    <= '0;
         pipe_reg   <= '0;
         half       <= 1'b0;
         fin        <= 1'b0;
         ciphertext <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         if (take) begin
            state_reg <= plaintext ^ key;
            key_reg   <= key;
            rnd       <= 4'd1;
            rcon      <= RCON_INIT;
            half      <= 1'b0;
            fin       <= 1'b0;
            busy      <= 1'b1;
            st        <= ST_ROUND;
         end else begin
            unique case (st)
               ST_ROUND: begin
                  // The result moves to the output register one cycle after
                  // the final round, giving 11 (or 21) cycles accept-to-valid.
                  if (fin) begin
                     ciphertext <= state_reg;
                     out_valid  <= 1'b1;
                     fin        <= 1'b0;
                     busy       <= 1'b0;
                     st         <= ST_DONE;
                  end else if (PIPE && !half) begin
                     pipe_reg <= sb_sr;
                     half     <= 1'b1;
                  end else begin
                     state_reg <= round_out;
                     key_reg   <= next_key;
                     rcon      <= xtime(rcon);
                     half      <= 1'b0;
                     if (rnd == RND_LAST) fin <= 1'b1;
                     else                 rnd <= rnd + 4'd1;
                  end
               end
               ST_DONE: begin
                  if (out_ready) st <= ST_IDLE;
               end
               default: ;
            endcase
         end
         if ((st == ST_DONE) && out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// tb_aes128_round_ctrl: scoreboard bench for aes128_round_ctrl, instantiating
// PIPE_RND=0 (index 0) and PIPE_RND=1 (index 1) side by side.
module tb_aes128_round_ctrl;

   typedef struct {
      logic [127:0] ct;
      int unsigned  due;
   } exp_t;

   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] RK1_B  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clk = 1'b0;
   logic [1:0]   rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] plaintext [2];
   logic [127:0] key [2];
   logic [127:0] ciphertext [2];

   int unsigned cyc = 0;
   int checks = 0;
   int errors = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      aes128_round_ctrl #(.NR(10), .PIPE_RND(gi)) u_dut (
         .clk        (clk),
         .rst        (rst[gi]),
         .in_valid   (in_valid[gi]),
         .in_ready   (in_ready[gi]),
         .plaintext  (plaintext[gi]),
         .key        (key[gi]),
         .out_valid  (out_valid[gi]),
         .out_ready  (out_ready[gi]),
         .ciphertext (ciphertext[gi]),
         .busy       (busy[gi])
      );
   end

   function automatic int unsigned lat(input int s);
      return (s == 0) ? 11 : 21;
   endfunction

   function automatic void q_push(input int s, input exp_t e);
      if (s == 0) q0.push_back(e); else q1.push_back(e);
   endfunction

   function automatic int q_size(input int s);
      return (s == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t q_front(input int s);
      return (s == 0) ? q0[0] : q1[0];
   endfunction

   function automatic exp_t q_pop(input int s);
      return (s == 0) ? q0.pop_front() : q1.pop_front();
   endfunction

   function automatic void q_clear(input int s);
      if (s == 0) q0.delete(); else q1.delete();
   endfunction

   function automatic void chk128(input string nm, input int s, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, s, act, req);
      end
   endfunction

   function automatic void chk1(input string nm, input int s, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s[%0d]: got %b expected %b", nm, s, act, req);
      end
   endfunction

   function automatic void chk_int(input string nm, input int s, input int unsigned act, input int unsigned req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d expected %0d", nm, s, act, req);
      end
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Monitor: checks out_valid rise timing and ciphertext on each transfer.
   initial begin : monitor
      exp_t e;
      logic [1:0] ov_prev;
      ov_prev = '0;
      forever begin
         @(negedge clk);
         #2;
         for (int s = 0; s < 2; s++) begin
            if (out_valid[s] && !ov_prev[s]) begin
               if (q_size(s) == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_out_valid[%0d]: got out_valid=1 at cycle %0d expected 0", s, cyc);
               end else begin
                  e = q_front(s);
                  chk_int("latency_cycle", s, cyc, e.due);
               end
            end
            if (out_valid[s] && out_ready[s] && q_size(s) != 0) begin
               e = q_pop(s);
               chk128("ciphertext", s, ciphertext[s], e.ct);
            end
            ov_prev[s] = out_valid[s];
         end
      end
   end

   task automatic send(input int s, input logic [127:0] pt, input logic [127:0] k,
                       input logic [127:0] ct, input bit hold, output int unsigned acc);
      exp_t e;
      int n;
      n = 0;
      acc = 0;
      @(negedge clk);
      plaintext[s] = pt;
      key[s]       = k;
      in_valid[s]  = 1'b1;
      #1;
      while (!in_ready[s] && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready[s]) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout[%0d]: got in_ready=0 expected 1 within 300 cycles", s);
         in_valid[s] = 1'b0;
         return;
      end
      acc   = cyc + 1;
      e.ct  = ct;
      e.due = acc + lat(s);
      q_push(s, e);
      @(posedge clk);
      #1;
      if (!hold) begin
         in_valid[s]  = 1'b0;
         plaintext[s] = rnd128();
         key[s]       = rnd128();
      end
   endtask

   // Waits for the scoreboard to empty while scrambling the idle inputs.
   task automatic wait_drain(input int s);
      int n;
      n = 0;
      while (q_size(s) != 0 && n < 400) begin
         @(negedge clk);
         if (!in_valid[s]) begin
            plaintext[s] = rnd128();
            key[s]       = rnd128();
         end
         n++;
      end
      if (q_size(s) != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout[%0d]: got %0d pending results expected 0", s, q_size(s));
         q_clear(s);
      end
      @(negedge clk);
      #3;
   endtask

   initial begin : watchdog
      #400000;
      errors++;
      $display("FAIL watchdog: got no completion expected finish before 400000 ns");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int unsigned acc1, acc2;
      int n;
      logic [127:0] k1;
      rst       = '1;
      in_valid  = '0;
      out_ready = '0;
      for (int s = 0; s < 2; s++) begin
         plaintext[s] = '0;
         key[s]       = '0;
      end
      repeat (2) @(negedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         chk1("reset_out_valid", s, out_valid[s], 1'b0);
         chk1("reset_in_ready", s, in_ready[s], 1'b1);
         chk1("reset_busy", s, busy[s], 1'b0);
         chk128("reset_ciphertext", s, ciphertext[s], '0);
      end
      rst = '0;

      for (int s = 0; s < 2; s++) begin
         out_ready[s] = 1'b1;

         // FIPS-197 C.1
         send(s, PT_C1, KEY_C1, CT_C1, 1'b0, acc1);
         wait_drain(s);

         // FIPS-197 App. B, plus the first expanded round key
         send(s, PT_B, KEY_B, CT_B, 1'b0, acc1);
         repeat (s + 1) @(posedge clk);
         #1;
         if (s == 0) k1 = g_dut[0].u_dut.key_reg;
         else        k1 = g_dut[1].u_dut.key_reg;
         chk128("round1_key", s, k1, RK1_B);
         wait_drain(s);

         // All-zero key and plaintext
         send(s, '0, '0, CT_Z, 1'b0, acc1);
         wait_drain(s);

         // Backpressure: result held for 20 cycles, no new accept
         out_ready[s] = 1'b0;
         send(s, PT_B, KEY_B, CT_B, 1'b0, acc1);
         n = 0;
         @(negedge clk);
         #1;
         while (!out_valid[s] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
         end
         in_valid[s]  = 1'b1;
         plaintext[s] = PT_C1;
         key[s]       = KEY_C1;
         for (int i = 0; i < 20; i++) begin
            chk1("bp_out_valid", s, out_valid[s], 1'b1);
            chk128("bp_ciphertext", s, ciphertext[s], CT_B);
            chk1("bp_in_ready", s, in_ready[s], 1'b0);
            @(negedge clk);
            #1;
         end
         in_valid[s]  = 1'b0;
         out_ready[s] = 1'b1;
         @(negedge clk);
         #1;
         chk1("bp_single_transfer", s, out_valid[s], 1'b0);
         chk_int("bp_queue_empty", s, q_size(s), 0);
         wait_drain(s);

         // Back-to-back: second block accepted in the DONE cycle
         send(s, PT_C1, KEY_C1, CT_C1, 1'b1, acc1);
         send(s, PT_B, KEY_B, CT_B, 1'b0, acc2);
         chk_int("b2b_accept_cycle", s, acc2, acc1 + lat(s) + 1);
         wait_drain(s);

         // Reset around round 5 aborts the block
         send(s, PT_C1, KEY_C1, CT_C1, 1'b0, acc1);
         repeat ((s == 0) ? 4 : 9) @(posedge clk);
         #1;
         chk1("pre_reset_busy", s, busy[s], 1'b1);
         #1;
         rst[s] = 1'b1;
         #1;
         chk1("abort_out_valid", s, out_valid[s], 1'b0);
         chk1("abort_in_ready", s, in_ready[s], 1'b1);
         chk1("abort_busy", s, busy[s], 1'b0);
         chk128("abort_ciphertext", s, ciphertext[s], '0);
         q_clear(s);
         @(negedge clk);
         rst[s] = 1'b0;
         repeat (30) @(negedge clk);
         #1;
         chk1("post_abort_no_output", s, out_valid[s], 1'b0);
         send(s, PT_C1, KEY_C1, CT_C1, 1'b0, acc1);
         wait_drain(s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
